// File: rtl/spi_pkg.sv
// Shared FSM state type, default SCLK divider and small helpers for the SPI master.
package spi_pkg;

    localparam int unsigned CLKDIV_DEFAULT = 32'd4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        WAIT     = 3'd4,
        END      = 3'd5
    } spi_state_e;

    // A byte may be offered only while idle, or between bytes when no end of message is pending.
    function automatic logic ready_in(input spi_state_e st, input logic end_pend);
        return (st == IDLE) || ((st == WAIT) && !end_pend);
    endfunction

endpackage

// File: rtl/spi_master.sv
// Byte-oriented SPI mode-0 master: MSB first, SSEL held low across back-to-back bytes
// until a message end is requested; every SPI-facing output is driven straight from a flop.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLKDIV = CLKDIV_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       spi_ssel_n,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    input  logic [7:0] txdata,
    input  logic       txdata_valid,
    output logic       txdata_ready,
    input  logic       msg_end,
    output logic [7:0] rxdata,
    output logic       rxdata_valid,
    output logic       busy
);

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 32'd1);

    spi_state_e state_r;
    spi_state_e state_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_s;
    logic [2:0] bit_r;
    logic [2:0] bit_s;
    logic [7:0] tx_sh_r;
    logic [7:0] tx_sh_s;
    logic [7:0] rx_sh_r;
    logic [7:0] rx_sh_s;
    logic       end_pend_r;
    logic       end_pend_s;
    logic       miso_r;
    logic       mosi_s;
    logic [7:0] rxdata_s;
    logic       rxv_s;
    logic       sclk_s;
    logic       ssel_n_s;
    logic       busy_s;
    logic       ready_s;
    logic       accept_s;
    logic       phase_done_s;

    assign accept_s     = txdata_valid && txdata_ready;
    assign phase_done_s = (cnt_r == DIV_LAST);

    // Outputs are registered copies of what the next state implies, so they change with the state.
    assign sclk_s   = (state_s == SHIFT_HI);
    assign ssel_n_s = (state_s == IDLE);
    assign busy_s   = (state_s != IDLE);
    assign ready_s  = ready_in(state_s, end_pend_s);

    // Next-state, counter and shifter logic for one byte transfer.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r + 8'd1;
        bit_s      = bit_r;
        tx_sh_s    = tx_sh_r;
        rx_sh_s    = rx_sh_r;
        end_pend_s = end_pend_r;
        mosi_s     = spi_mosi;
        rxdata_s   = rxdata;
        rxv_s      = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_s      = 8'd0;
                end_pend_s = 1'b0;
                if (accept_s) begin
                    state_s = SETUP;
                    tx_sh_s = txdata;
                    mosi_s  = txdata[7];
                    bit_s   = 3'd0;
                end else begin
                    mosi_s  = 1'b0;
                end
            end
            SETUP: begin
                end_pend_s = end_pend_r | msg_end;
                if (phase_done_s) begin
                    state_s = SHIFT_HI;
                    cnt_s   = 8'd0;
                end else begin
                    state_s = SETUP;
                end
            end
            SHIFT_HI: begin
                end_pend_s = end_pend_r | msg_end;
                if (phase_done_s) begin
                    // Sample on the last high cycle; present the next bit as SCLK falls.
                    state_s = SHIFT_LO;
                    cnt_s   = 8'd0;
                    rx_sh_s = {rx_sh_r[6:0], miso_r};
                    tx_sh_s = {tx_sh_r[6:0], 1'b0};
                    mosi_s  = tx_sh_r[6];
                end else begin
                    state_s = SHIFT_HI;
                end
            end
            SHIFT_LO: begin
                end_pend_s = end_pend_r | msg_end;
                if (phase_done_s) begin
                    cnt_s = 8'd0;
                    bit_s = bit_r + 3'd1;
                    if (bit_r == 3'd7) begin
                        state_s  = WAIT;
                        rxdata_s = rx_sh_r;
                        rxv_s    = 1'b1;
                    end else begin
                        state_s  = SHIFT_HI;
                    end
                end else begin
                    state_s = SHIFT_LO;
                end
            end
            WAIT: begin
                cnt_s = 8'd0;
                if (end_pend_r) begin
                    state_s    = END;
                    end_pend_s = 1'b0;
                end else if (accept_s) begin
                    // A simultaneous msg_end closes the message after this byte.
                    state_s    = SETUP;
                    tx_sh_s    = txdata;
                    mosi_s     = txdata[7];
                    end_pend_s = msg_end;
                end else if (msg_end) begin
                    state_s    = END;
                end else begin
                    state_s    = WAIT;
                end
            end
            END: begin
                if (phase_done_s) begin
                    state_s = IDLE;
                    cnt_s   = 8'd0;
                    mosi_s  = 1'b0;
                end else begin
                    state_s = END;
                end
            end
            default: begin
                state_s    = IDLE;
                cnt_s      = 8'd0;
                bit_s      = 3'd0;
                end_pend_s = 1'b0;
                mosi_s     = 1'b0;
            end
        endcase
    end

    // State, counters, shifters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            cnt_r        <= 8'd0;
            bit_r        <= 3'd0;
            tx_sh_r      <= 8'd0;
            rx_sh_r      <= 8'd0;
            end_pend_r   <= 1'b0;
            spi_ssel_n   <= 1'b1;
            spi_sclk     <= 1'b0;
            spi_mosi     <= 1'b0;
            rxdata       <= 8'd0;
            rxdata_valid <= 1'b0;
            txdata_ready <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            bit_r        <= bit_s;
            tx_sh_r      <= tx_sh_s;
            rx_sh_r      <= rx_sh_s;
            end_pend_r   <= end_pend_s;
            spi_ssel_n   <= ssel_n_s;
            spi_sclk     <= sclk_s;
            spi_mosi     <= mosi_s;
            rxdata       <= rxdata_s;
            rxdata_valid <= rxv_s;
            txdata_ready <= ready_s;
            busy         <= busy_s;
        end
    end

    // MISO is asynchronous to clk; register it once before it reaches the shifter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miso_r <= 1'b0;
        end else begin
            miso_r <= spi_miso;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: a fast instance (CLKDIV=2) with a mode-0 slave model,
// and a slow instance (CLKDIV=255) with valid held to measure half-periods.
module tb_spi_master;

    localparam int FAST_DIV = 2;
    localparam int SLOW_DIV = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n      = 1'b0;
    logic       spi_ssel_n;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso     = 1'b0;
    logic [7:0] txdata       = 8'h00;
    logic       txdata_valid = 1'b0;
    logic       txdata_ready;
    logic       msg_end      = 1'b0;
    logic [7:0] rxdata;
    logic       rxdata_valid;
    logic       busy;

    logic       s_reset_n = 1'b0;
    logic       s_ssel_n;
    logic       s_sclk;
    logic       s_mosi;
    logic [7:0] s_txdata  = 8'h5A;
    logic       s_valid   = 1'b0;
    logic       s_ready;
    logic [7:0] s_rxdata;
    logic       s_rxv;
    logic       s_busy;

    spi_master #(.CLKDIV(FAST_DIV)) u_dut (
        .clk(clk), .reset_n(reset_n), .spi_ssel_n(spi_ssel_n), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .txdata(txdata), .txdata_valid(txdata_valid),
        .txdata_ready(txdata_ready), .msg_end(msg_end), .rxdata(rxdata),
        .rxdata_valid(rxdata_valid), .busy(busy)
    );

    spi_master #(.CLKDIV(SLOW_DIV)) u_slow (
        .clk(clk), .reset_n(s_reset_n), .spi_ssel_n(s_ssel_n), .spi_sclk(s_sclk),
        .spi_mosi(s_mosi), .spi_miso(1'b1), .txdata(s_txdata), .txdata_valid(s_valid),
        .txdata_ready(s_ready), .msg_end(1'b0), .rxdata(s_rxdata),
        .rxdata_valid(s_rxv), .busy(s_busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_rx_q[$];
    logic [7:0] slave_q[$];

    int rxv_cnt       = 0;
    int sclk_rises    = 0;
    int ssel_rises    = 0;
    int ssel_falls    = 0;
    int ssel_fall_cyc = 0;
    int ssel_rise_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Fast-instance monitor and mode-0 slave: samples MOSI on SCLK rise, shifts MISO on SCLK fall.
    initial begin : fast_monitor
        logic       prev_ssel_n;
        logic       prev_sclk;
        logic       prev_rxv;
        logic [7:0] s_byte;
        logic [7:0] s_rx;
        int         s_bits;
        prev_ssel_n = 1'b1;
        prev_sclk   = 1'b0;
        prev_rxv    = 1'b0;
        s_byte      = 8'h00;
        s_rx        = 8'h00;
        s_bits      = 0;
        forever begin
            @(negedge clk);
            if (prev_ssel_n && !spi_ssel_n) begin
                ssel_falls++;
                ssel_fall_cyc = cyc;
                s_bits = 0;
                s_byte = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
                spi_miso = s_byte[7];
            end
            if (!prev_ssel_n && spi_ssel_n) begin
                ssel_rises++;
                ssel_rise_cyc = cyc;
                spi_miso = 1'b0;
            end
            if (!prev_sclk && spi_sclk) begin
                sclk_rises++;
                s_rx = {s_rx[6:0], spi_mosi};
                s_bits++;
                if (s_bits % 8 == 0) begin
                    if (exp_tx_q.size() == 0) chk("unexpected mosi byte", 32'(s_rx), 32'hFFFF_FFFF);
                    else chk("mosi byte", 32'(s_rx), 32'(exp_tx_q.pop_front()));
                end
            end
            if (prev_sclk && !spi_sclk && !spi_ssel_n) begin
                if (s_bits % 8 == 0) s_byte = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
                else s_byte = {s_byte[6:0], 1'b0};
                spi_miso = s_byte[7];
            end
            if (rxdata_valid) begin
                rxv_cnt++;
                if (exp_rx_q.size() == 0) chk("unexpected rxdata_valid", 32'(rxdata), 32'hFFFF_FFFF);
                else chk("rxdata", 32'(rxdata), 32'(exp_rx_q.pop_front()));
                if (prev_rxv) chk("rxdata_valid single cycle", 32'd2, 32'd1);
            end
            prev_ssel_n = spi_ssel_n;
            prev_sclk   = spi_sclk;
            prev_rxv    = rxdata_valid;
        end
    end

    // Offer one byte and queue what the slave returns and what MOSI must carry.
    task automatic send(input logic [7:0] d, input logic [7:0] resp);
        bit got;
        got = 1'b0;
        slave_q.push_back(resp);
        exp_tx_q.push_back(d);
        exp_rx_q.push_back(resp);
        txdata = d;
        txdata_valid = 1'b1;
        for (int i = 0; i < 3000 && !got; i++) begin
            if (txdata_ready) got = 1'b1;
            @(negedge clk);
        end
        txdata_valid = 1'b0;
        chk("txdata accepted", 32'(got), 32'd1);
    endtask

    task automatic wait_rxv(output int at_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (rxdata_valid) seen = 1'b1;
        end
        at_cyc = cyc;
        chk("rxdata_valid arrives", 32'(seen), 32'd1);
    endtask

    task automatic wait_rises(input int base, input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (sclk_rises - base >= n) seen = 1'b1;
        end
        chk("sclk edges reached", 32'(seen), 32'd1);
    endtask

    task automatic wait_idle();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (spi_ssel_n && !busy) seen = 1'b1;
        end
        @(negedge clk);
        chk("returns to idle", 32'(seen), 32'd1);
    endtask

    task automatic pulse_end();
        msg_end = 1'b1;
        @(negedge clk);
        msg_end = 1'b0;
    endtask

    task automatic run_fast();
        int w;
        int w2;
        int b_rise;
        int b_ssel;
        int b_fall;
        int b_rxv;
        repeat (3) @(negedge clk);
        chk("reset ssel_n", 32'(spi_ssel_n), 32'd1);
        chk("reset sclk", 32'(spi_sclk), 32'd0);
        chk("reset mosi", 32'(spi_mosi), 32'd0);
        chk("reset rxdata", 32'(rxdata), 32'd0);
        chk("reset rxdata_valid", 32'(rxdata_valid), 32'd0);
        chk("reset txdata_ready", 32'(txdata_ready), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        #1 chk("ready before first edge", 32'(txdata_ready), 32'd0);
        @(posedge clk);
        #1 chk("ready after first edge", 32'(txdata_ready), 32'd1);
        @(negedge clk);

        // A5 out, slave returns 3C; WAIT is reached 17 half-periods after SETUP entry.
        b_rise = sclk_rises;
        send(8'hA5, 8'h3C);
        wait_rxv(w);
        chk("byte time", 32'(w - ssel_fall_cyc), 32'(17 * FAST_DIV));
        pulse_end();
        wait_idle();
        chk("ssel rise after end", 32'(ssel_rise_cyc - w), 32'(FAST_DIV + 1));
        chk("edges single byte", 32'(sclk_rises - b_rise), 32'd8);

        // Back-to-back bytes inside one SSEL window.
        b_rise = sclk_rises;
        b_ssel = ssel_rises;
        b_fall = ssel_falls;
        send(8'h01, 8'h81);
        send(8'h80, 8'h7E);
        wait_rxv(w);
        pulse_end();
        wait_idle();
        chk("edges two bytes", 32'(sclk_rises - b_rise), 32'd16);
        chk("ssel falls two bytes", 32'(ssel_falls - b_fall), 32'd1);
        chk("ssel rises two bytes", 32'(ssel_rises - b_ssel), 32'd1);
        chk("ssel rise after two bytes", 32'(ssel_rise_cyc - w), 32'(FAST_DIV + 1));

        // msg_end mid-byte is held until the byte completes.
        b_rise = sclk_rises;
        b_rxv  = rxv_cnt;
        send(8'hFF, 8'h55);
        wait_rises(b_rise, 3);
        pulse_end();
        wait_rxv(w);
        wait_idle();
        chk("edges latched end", 32'(sclk_rises - b_rise), 32'd8);
        chk("rxv count latched end", 32'(rxv_cnt - b_rxv), 32'd1);
        chk("ssel rise latched end", 32'(ssel_rise_cyc - w), 32'(FAST_DIV + 1));

        // Accept and msg_end together in WAIT: that byte goes out, nothing after it.
        b_rise = sclk_rises;
        send(8'hC3, 8'h18);
        slave_q.push_back(8'hE7);
        exp_tx_q.push_back(8'h99);
        exp_rx_q.push_back(8'hE7);
        wait_rxv(w);
        chk("ready in WAIT", 32'(txdata_ready), 32'd1);
        txdata = 8'h99;
        txdata_valid = 1'b1;
        msg_end = 1'b1;
        @(negedge clk);
        msg_end = 1'b0;
        txdata = 8'h11;
        wait_rxv(w2);
        chk("ready low with end pending", 32'(txdata_ready), 32'd0);
        txdata_valid = 1'b0;
        wait_idle();
        chk("edges accept+end", 32'(sclk_rises - b_rise), 32'd16);
        chk("ssel rise accept+end", 32'(ssel_rise_cyc - w2), 32'(FAST_DIV + 1));

        // Reset during a high SCLK phase aborts at once.
        b_rise = sclk_rises;
        send(8'h6B, 8'hD2);
        wait_rises(b_rise, 5);
        chk("sclk high before abort", 32'(spi_sclk), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort ssel_n", 32'(spi_ssel_n), 32'd1);
        chk("abort sclk", 32'(spi_sclk), 32'd0);
        chk("abort mosi", 32'(spi_mosi), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort ready", 32'(txdata_ready), 32'd0);
        exp_tx_q.delete();
        exp_rx_q.delete();
        slave_q.delete();
        b_rxv = rxv_cnt;
        repeat (3) @(negedge clk);
        chk("abort rxdata", 32'(rxdata), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("no rxv after abort", 32'(rxv_cnt - b_rxv), 32'd0);
        send(8'h2D, 8'hB4);
        wait_rxv(w);
        pulse_end();
        wait_idle();
        chk("byte after abort rxdata", 32'(rxdata), 32'hB4);
    endtask

    task automatic run_slow();
        logic       p_sclk;
        logic [7:0] rx;
        int         hi_start;
        int         lo_start;
        int         rises;
        int         bytes;
        int         ready_hi;
        p_sclk = 1'b0;
        rx = 8'h00;
        hi_start = 0;
        lo_start = 0;
        rises = 0;
        bytes = 0;
        ready_hi = 0;
        repeat (3) @(negedge clk);
        s_reset_n = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 12000 && bytes < 2; i++) begin
            @(negedge clk);
            if (s_ready) ready_hi++;
            if (s_ready && s_sclk) chk("slow ready while sclk high", 32'd1, 32'd0);
            if (!p_sclk && s_sclk) begin
                if (rises > 0) chk("slow low half-period", 32'(cyc - lo_start), 32'(SLOW_DIV));
                rises++;
                hi_start = cyc;
                rx = {rx[6:0], s_mosi};
            end
            if (p_sclk && !s_sclk) begin
                chk("slow high half-period", 32'(cyc - hi_start), 32'(SLOW_DIV));
                lo_start = cyc;
            end
            if (s_rxv) begin
                bytes++;
                chk("slow edges per byte", 32'(rises), 32'd8);
                chk("slow mosi byte", 32'(rx), 32'h5A);
                chk("slow rxdata", 32'(s_rxdata), 32'hFF);
                rises = 0;
            end
            p_sclk = s_sclk;
        end
        chk("slow bytes", 32'(bytes), 32'd2);
        chk("slow ready cycles", 32'(ready_hi), 32'd3);
        chk("slow ssel held", 32'(s_ssel_n), 32'd0);
        chk("slow busy", 32'(s_busy), 32'd1);
    endtask

    initial begin
        fork
            run_fast();
            run_slow();
        join
        chk("rx queue drained", 32'(exp_rx_q.size()), 32'd0);
        chk("tx queue drained", 32'(exp_tx_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
